bin2bcd_serial: RTL and testbench

BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

---
 rtl/bin2bcd_serial.sv | 138 +++++++++++++
 tb/tb_bin2bcd_serial.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial
//   Serial 8-bit binary to 3-digit BCD converter using shift-and-add-3
//   (double dabble). One iteration per clock; a conversion takes 9 cycles
//   from the accepting edge to the Done pulse, 10 cycles back-to-back.
//
// Ports
//   Clock      in   single clock, rising edge
//   Reset      in   synchronous, active-high
//   Start      in   conversion request, only looked at in IDLE
//   Bin[7:0]   in   value to convert, captured on the accepting edge
//   Busy       out  high in SHIFT and DONE
//   Done       out  one-cycle pulse when BCD2..BCD0 carry a new result
//   BCD2[3:0]  out  hundreds digit (0-2)
//   BCD1[3:0]  out  tens digit (0-9)
//   BCD0[3:0]  out  units digit (0-9)
//   Blank2     out  hundreds digit is zero   (only with BIN2BCD_BLANK_EN)
//   Blank1     out  hundreds and tens zero   (only with BIN2BCD_BLANK_EN)
//   dbg_state  out  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Optional feature macro: BIN2BCD_BLANK_EN adds the registered
// leading-zero flags Blank2/Blank1. Without it those ports do not exist.
//
// Handshake: a request is accepted on a rising edge where the FSM is in
// IDLE and Start is high; Start at any other time is dropped, never queued.
// The result is valid on BCD2..BCD0 in the cycle Done is high and is held
// there until the next Done.

module bin2bcd_serial (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Bin,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] BCD2,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
`ifdef BIN2BCD_BLANK_EN
    output logic       Blank2,
    output logic       Blank1,
`endif
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // {hundreds, tens, units, binary} -- binary bits shift out of the top
    // of the low byte into the units nibble.
    logic [19:0] work;
    logic [19:0] work_adj;
    logic [19:0] work_step;
    logic [2:0]  cnt;
    logic        last_iter;

    assign last_iter = (cnt == 3'd7);

    // One double-dabble iteration: correct each BCD nibble, then shift.
    always_comb begin
        work_adj = work;
        if (work[19:16] >= 4'd5) work_adj[19:16] = work[19:16] + 4'd3;
        if (work[15:12] >= 4'd5) work_adj[15:12] = work[15:12] + 4'd3;
        if (work[11:8]  >= 4'd5) work_adj[11:8]  = work[11:8]  + 4'd3;
        work_step = {work_adj[18:0], 1'b0};
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start) state_nxt = SHIFT;
            SHIFT:   if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy      = (state != IDLE);
        Done      = (state == DONE);
        dbg_state = state;
    end

    // Datapath: work register, iteration counter and result registers.
    // The result registers are written only on the final iteration so that
    // partial sums never reach the digit decoders.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            work <= '0;
            cnt  <= '0;
            BCD2 <= '0;
            BCD1 <= '0;
            BCD0 <= '0;
`ifdef BIN2BCD_BLANK_EN
            Blank2 <= 1'b1;
            Blank1 <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        work <= {12'd0, Bin};
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    work <= work_step;
                    // Counter parks at 7; leaving SHIFT ends the iterations.
                    if (!last_iter) cnt <= cnt + 3'd1;
                    if (last_iter) begin
                        BCD2 <= work_step[19:16];
                        BCD1 <= work_step[15:12];
                        BCD0 <= work_step[11:8];
`ifdef BIN2BCD_BLANK_EN
                        Blank2 <= (work_step[19:16] == 4'd0);
                        Blank1 <= (work_step[19:12] == 8'd0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb_bin2bcd_serial
//   Self-checking bench for bin2bcd_serial. Stimulus drives requests one
//   time unit after each rising edge; a reference model derived from plain
//   decimal arithmetic pushes the expected digits (and leading-zero flags)
//   into a queue on each accepted request, and a monitor on the falling
//   edge pops and compares whenever Done is seen. Build with
//   BIN2BCD_BLANK_EN defined to cover the Blank2/Blank1 flags.

module tb_bin2bcd_serial;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [7:0] Bin;
  logic       Busy;
  logic       Done;
  logic [3:0] BCD2;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic [1:0] dbg_state;
`ifdef BIN2BCD_BLANK_EN
  logic       Blank2;
  logic       Blank1;
  localparam logic [13:0] CMP_MASK = 14'h3fff;
`else
  localparam logic [13:0] CMP_MASK = 14'h0fff;
`endif

  bin2bcd_serial dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Bin       (Bin),
    .Busy      (Busy),
    .Done      (Done),
    .BCD2      (BCD2),
    .BCD1      (BCD1),
    .BCD0      (BCD0),
`ifdef BIN2BCD_BLANK_EN
    .Blank2    (Blank2),
    .Blank1    (Blank1),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [13:0] exp_q[$];   // {blank2, blank1, d2, d1, d0}
  int          acc_q[$];   // cycle number of the accepting edge
  logic [13:0] last_res;
  int          compared = 0;
  int          mismatched = 0;
  bit          b2b_mode = 0;
  int          last_done_cyc = -1;

  // Reference: decimal digits by division, flags by magnitude.
  function automatic logic [13:0] model(input logic [7:0] b);
    int v;
    logic [3:0] d2, d1, d0;
    v  = int'(b);
    d2 = 4'(v / 100);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {(v < 100), (v < 10), d2, d1, d0};
  endfunction

  function automatic logic [13:0] dut_out();
`ifdef BIN2BCD_BLANK_EN
    return {Blank2, Blank1, BCD2, BCD1, BCD0};
`else
    return {2'b11, BCD2, BCD1, BCD0};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clock) begin
    if (!Reset) begin
      if (Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(dut_out() & CMP_MASK), 32'hffff_ffff);
        end else begin
          logic [13:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result", 32'(dut_out() & CMP_MASK), 32'(e & CMP_MASK));
          check("latency", 32'(cyc - a), 32'd8);
          if (b2b_mode && last_done_cyc >= 0)
            check("b2b_period", 32'(cyc - last_done_cyc), 32'd10);
          last_res = e;
        end
        last_done_cyc = cyc;
      end else begin
        check("hold", 32'(dut_out() & CMP_MASK), 32'(last_res & CMP_MASK));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Request for exactly one cycle; the model is consulted only when the
  // DUT is idle, since that is the only time the request is accepted.
  task automatic issue(input logic [7:0] b);
    Start = 1'b1;
    Bin   = b;
    if (!Busy && !Reset) begin
      exp_q.push_back(model(b));
      acc_q.push_back(cyc + 1);
    end
    tick();
    Start = 1'b0;
    Bin   = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    last_res = 14'h3000;
    tick();
    Reset = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_bcd", 32'({BCD2, BCD1, BCD0}), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    check("rst_blank", 32'({Blank2, Blank1}), 32'd3);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    Reset    = 1'b1;
    Start    = 1'b0;
    Bin      = 8'd0;
    last_res = 14'h3000;
    tick();
    apply_reset();
    check_reset_state();

    // 255 with Busy duration
    repeat (2) tick();
    issue(8'd255);
    n = 0;
    while (Busy && n < 30) begin
      n++;
      tick();
    end
    check("busy_cycles", 32'(n), 32'd9);
    wait_idle();

    // zero, and the 99/100 boundary
    issue(8'd0);
    wait_idle();
    issue(8'd99);
    wait_idle();
    issue(8'd100);
    wait_idle();

    // Start during conversion is ignored
    issue(8'd42);
    repeat (2) tick();
    issue(8'd200);
    wait_idle();
    repeat (15) tick();

    // reset mid-conversion aborts
    issue(8'd137);
    repeat (3) tick();
    apply_reset();
    check_reset_state();
    repeat (12) tick();
    issue(8'd137);
    wait_idle();

    // exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      issue(8'(v));
      wait_idle();
    end

    // random values with random idle gaps, issued without waiting
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom));
      repeat ($urandom_range(0, 12)) tick();
    end
    wait_idle();

    // back-to-back with Start held high
    b2b_mode      = 1'b1;
    last_done_cyc = -1;
    Start         = 1'b1;
    for (int i = 0; i < 60; i++) begin
      Bin = 8'($urandom);
      if (!Busy) begin
        exp_q.push_back(model(Bin));
        acc_q.push_back(cyc + 1);
      end
      tick();
    end
    Start = 1'b0;
    wait_idle();
    b2b_mode = 1'b0;
    repeat (5) tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
